// File: rtl/alu_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : alu_pkg                                                          |
// | Brief   : Op codes, FSM states and op classification for alu_seq.          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLT    = 5'd2,
    ALU_SLTU   = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_OR     = 5'd5,
    ALU_AND    = 5'd6,
    ALU_SLL    = 5'd7,
    ALU_SRL    = 5'd8,
    ALU_SRA    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // Multiply/divide ops run on the iterative engine; everything else is single-cycle.
  function automatic logic is_mop(input alu_op_e op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : alu_seq_if                                                     |
// | Brief     : Operand-side and result-side valid/ready bundle of alu_seq.    |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface alu_seq_if #(
  parameter int XLEN = 32
);
  import alu_pkg::*;

  logic            i_valid;
  logic            o_ready;
  logic [XLEN-1:0] i_op_a;
  logic [XLEN-1:0] i_op_b;
  alu_op_e         i_alu_op;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_alu_data;
  logic            o_busy;

  modport slave (
    input  i_valid, i_op_a, i_op_b, i_alu_op, i_flush, i_ready,
    output o_ready, o_valid, o_alu_data, o_busy
  );

  modport master (
    output i_valid, i_op_a, i_op_b, i_alu_op, i_flush, i_ready,
    input  o_ready, o_valid, o_alu_data, o_busy
  );

endinterface
`default_nettype wire

// File: rtl/alu_seq_mdu_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mdu_iter                                                          |
// | Brief  : Iterative multiply/divide, one bit per i_step. Operands are made  |
// |          magnitudes at i_start, the sign is restored on the way out, and   |
// |          divide-by-zero / signed overflow are resolved explicitly.         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_step,
  input  alu_op_e         i_op,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic [XLEN-1:0] o_result
);

  localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

  logic            w_is_div, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_mag_a, w_mag_b;

  alu_op_e         r_op;
  logic [XLEN-1:0] r_a, r_operand;
  logic            r_is_div, r_neg_q, r_neg_r, r_divz, r_ovf;
  // Multiply: {partial high, multiplier shifting out}. Divide: {remainder, quotient}.
  logic [2*XLEN-1:0] r_prod;

  logic [XLEN:0]     w_sum, w_shift;
  logic              w_geq;
  logic [XLEN-1:0]   w_diff, w_rem_next;
  logic [2*XLEN-1:0] w_prod_next;

  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo, w_rem;

  // Start-time sign fixup: turn signed operands into magnitudes.
  always_comb begin
    w_is_div = i_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    w_a_neg  = (i_op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM}) & i_op_a[XLEN-1];
    w_b_neg  = (i_op inside {ALU_MULH, ALU_DIV, ALU_REM}) & i_op_b[XLEN-1];
    w_mag_a  = w_a_neg ? -i_op_a : i_op_a;
    w_mag_b  = w_b_neg ? -i_op_b : i_op_b;
  end

  // One shift-add (multiply) or restoring-subtract (divide) iteration.
  always_comb begin
    w_sum      = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_operand} : '0);
    w_shift    = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
    w_geq      = (w_shift >= {1'b0, r_operand});
    // Truncated difference is exact whenever w_geq, since the remainder stays below the divisor.
    w_diff     = w_shift[XLEN-1:0] - r_operand;
    w_rem_next = w_geq ? w_diff : w_shift[XLEN-1:0];
    if (r_is_div) begin
      w_prod_next = {w_rem_next, r_prod[XLEN-2:0], w_geq};
    end else begin
      w_prod_next = {w_sum, r_prod[XLEN-1:1]};
    end
  end

  // Capture operands on start, then advance one bit per step.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op      <= ALU_ADD;
      r_a       <= '0;
      r_operand <= '0;
      r_is_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_divz    <= 1'b0;
      r_ovf     <= 1'b0;
      r_prod    <= '0;
    end else if (i_start) begin
      r_op      <= i_op;
      r_a       <= i_op_a;
      r_operand <= w_is_div ? w_mag_b : w_mag_a;
      r_is_div  <= w_is_div;
      r_neg_q   <= w_a_neg ^ w_b_neg;
      r_neg_r   <= w_a_neg;
      r_divz    <= (i_op_b == '0);
      r_ovf     <= (i_op inside {ALU_DIV, ALU_REM}) && (i_op_a == c_int_min) && (i_op_b == '1);
      r_prod    <= w_is_div ? {{XLEN{1'b0}}, w_mag_a} : {{XLEN{1'b0}}, w_mag_b};
    end else if (i_step) begin
      r_prod    <= w_prod_next;
    end
  end

  // End-time sign restore and special-case selection.
  always_comb begin
    w_prod_fix = r_neg_q ? -r_prod : r_prod;
    w_quo      = r_neg_q ? -r_prod[XLEN-1:0] : r_prod[XLEN-1:0];
    w_rem      = r_neg_r ? -r_prod[2*XLEN-1:XLEN] : r_prod[2*XLEN-1:XLEN];
    o_result   = '0;
    case (r_op)
      ALU_MUL:                        o_result = w_prod_fix[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: o_result = w_prod_fix[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:              o_result = r_divz ? '1 : (r_ovf ? r_a : w_quo);
      ALU_REM, ALU_REMU:              o_result = r_divz ? r_a : (r_ovf ? '0 : w_rem);
      default:                        o_result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : alu_seq                                                           |
// | Brief  : Sequential RV32I/RV32M ALU with valid/ready on both sides.        |
// |          Simple ops register in one cycle; M-ops run on mdu_iter.          |
// |          Define ALU_SEQ_MULDIV_EN to build the multiply/divide engine;     |
// |          without it, codes 10-17 return 0 like any other simple op.        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic     i_clk,
  input logic     i_rst_n,
  alu_seq_if.slave bus
);

  localparam int SHAMT_W = $clog2(XLEN);

  alu_state_e       r_state, w_state_next;
  logic             r_valid;
  logic [XLEN-1:0]  r_data;
  logic             w_ready, w_busy, w_accept, w_accept_mop, w_last;
  logic [SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0]  w_simple, w_mdu_result;

  assign w_accept = bus.i_valid & w_ready;

`ifdef ALU_SEQ_MULDIV_EN
  logic [SHAMT_W-1:0] r_count;

  assign w_accept_mop = w_accept & is_mop(bus.i_alu_op);
  assign w_last       = (r_count == SHAMT_W'(XLEN-1));

  // Iteration counter: cleared on an M-op accept, advances once per BUSY cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (w_accept_mop) begin
      r_count <= '0;
    end else if (r_state == BUSY) begin
      r_count <= r_count + 1'b1;
    end
  end

  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (w_accept_mop),
    .i_step   (r_state == BUSY),
    .i_op     (bus.i_alu_op),
    .i_op_a   (bus.i_op_a),
    .i_op_b   (bus.i_op_b),
    .o_result (w_mdu_result)
  );
`else
  assign w_accept_mop = 1'b0;
  assign w_last       = 1'b1;
  assign w_mdu_result = '0;
`endif

  // Single-cycle datapath; M-op codes and unused codes fall through to 0.
  always_comb begin
    w_shamt  = bus.i_op_b[SHAMT_W-1:0];
    w_simple = '0;
    case (bus.i_alu_op)
      ALU_ADD:  w_simple = bus.i_op_a + bus.i_op_b;
      ALU_SUB:  w_simple = bus.i_op_a - bus.i_op_b;
      ALU_SLT:  w_simple = {{(XLEN-1){1'b0}}, $signed(bus.i_op_a) < $signed(bus.i_op_b)};
      ALU_SLTU: w_simple = {{(XLEN-1){1'b0}}, bus.i_op_a < bus.i_op_b};
      ALU_XOR:  w_simple = bus.i_op_a ^ bus.i_op_b;
      ALU_OR:   w_simple = bus.i_op_a | bus.i_op_b;
      ALU_AND:  w_simple = bus.i_op_a & bus.i_op_b;
      ALU_SLL:  w_simple = bus.i_op_a << w_shamt;
      ALU_SRL:  w_simple = bus.i_op_a >> w_shamt;
      ALU_SRA:  w_simple = $unsigned($signed(bus.i_op_a) >>> w_shamt);
      default:  w_simple = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state; flush returns to IDLE from anywhere.
  always_comb begin
    w_state_next = r_state;
    if (bus.i_flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept_mop) w_state_next = BUSY;
        BUSY:    if (w_last)       w_state_next = DONE;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // FSM outputs: accept only when idle and the output slot is free or draining.
  always_comb begin
    w_ready = (r_state == IDLE) & (~r_valid | bus.i_ready) & ~bus.i_flush;
`ifdef ALU_SEQ_MULDIV_EN
    w_busy  = (r_state == BUSY);
`else
    w_busy  = 1'b0;
`endif
  end

  // Output register: load on simple accept or DONE, hold until consumed.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (bus.i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept & ~w_accept_mop) begin
      r_valid <= 1'b1;
      r_data  <= w_simple;
    end else if (r_state == DONE) begin
      r_valid <= 1'b1;
      r_data  <= w_mdu_result;
    end else if (r_valid & bus.i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.o_ready    = w_ready;
  assign bus.o_valid    = r_valid;
  assign bus.o_alu_data = r_data;
  assign bus.o_busy     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_alu_seq                                                        |
// | Brief  : Scoreboard bench for alu_seq: directed cases plus random traffic  |
// |          against a behavioural model. Honours ALU_SEQ_MULDIV_EN.           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_alu_seq;
  import alu_pkg::*;

  localparam int XLEN = 32;
`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    int          acc_cyc;
    int          lat;
    int          op;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.XLEN(XLEN)) bus ();

  alu_seq #(.XLEN(XLEN)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   m_wait = 0;   // cycles of engine activity still to go before a result appears
  bit   m_held = 0;   // a result is being presented
  bit   held_prev = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    int ia, ib;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    if (op >= 10 && op <= 17 && !MD_EN) return 32'd0;
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a ^ b;
      5:  return a | b;
      6:  return a & b;
      7:  return a << b[4:0];
      8:  return a >> b[4:0];
      9:  return $signed(a) >>> b[4:0];
      10: begin p = ua * ub; return p[31:0]; end
      11: begin p = sa * sb; return p[63:32]; end
      12: begin p = sa * $signed(ub); return p[63:32]; end
      13: begin p = ua * ub; return p[63:32]; end
      14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      16: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      17: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_m(input int op);
    return MD_EN && op >= 10 && op <= 17;
  endfunction

  // One clock of stimulus: drive, check handshake, score accept, advance model.
  task automatic step(input bit v, input int op, input logic [31:0] a, input logic [31:0] b,
                      input bit rdy, input bit fl);
    bit exp_rdy, acc;
    @(negedge clk);
    bus.i_valid  = v;
    bus.i_alu_op = alu_op_e'(op[4:0]);
    bus.i_op_a   = a;
    bus.i_op_b   = b;
    bus.i_ready  = rdy;
    bus.i_flush  = fl;
    #1;
    exp_rdy = (m_wait == 0) && (!m_held || rdy) && !fl;
    check("o_ready", bus.o_ready, exp_rdy);
    check("o_busy", bus.o_busy, m_wait >= 2);
    acc = v && bus.o_ready;
    if (acc) q.push_back('{ref_alu(op, a, b), cyc, is_m(op) ? XLEN + 2 : 1, op});
    @(posedge clk);
    if (fl) begin
      m_wait = 0;
      m_held = 0;
      q.delete();
    end else begin
      if (m_held && rdy) m_held = 0;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_held = 1;
      end
      if (acc) begin
        if (is_m(op)) m_wait = XLEN + 1;
        else          m_held = 1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    m_wait = 0;
    m_held = 0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_valid", bus.o_valid, 0);
    check("reset_data", bus.o_alu_data, 0);
    check("reset_busy", bus.o_busy, 0);
  endtask

  // Keep presenting junk while the engine works; it must not be accepted or disturb the result.
  task automatic wait_engine();
    while (m_wait > 0) step(1'b1, $urandom_range(0, 9), $urandom, $urandom, 1'b1, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every presented result is compared against the scoreboard head.
  always @(negedge clk) begin
    #1;
    if (rst_n && !bus.i_flush && bus.o_valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        if (!held_prev) check("latency", cyc - q[0].acc_cyc, q[0].lat);
        check("data", bus.o_alu_data, q[0].data);
        if (bus.i_ready) begin
          void'(q.pop_front());
          held_prev = 0;
        end else begin
          held_prev = 1;
        end
      end
    end else begin
      held_prev = 0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_valid  = 1'b0;
    bus.i_alu_op = ALU_ADD;
    bus.i_op_a   = '0;
    bus.i_op_b   = '0;
    bus.i_flush  = 1'b0;
    bus.i_ready  = 1'b1;
    do_reset();

    // Arithmetic wrap
    step(1, 0, 32'h7FFF_FFFF, 32'd1, 1, 0);
    step(1, 1, 32'd0, 32'd1, 1, 0);
    // Shift amount masking and compares
    step(1, 9, 32'h8000_0000, 32'h21, 1, 0);
    step(1, 2, 32'hFFFF_FFFF, 32'd1, 1, 0);
    step(1, 3, 32'hFFFF_FFFF, 32'd1, 1, 0);
    step(1, 20, 32'h1234, 32'h5678, 1, 0);
    // High-half multiplies
    step(1, 11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0); wait_engine();
    step(1, 13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0); wait_engine();
    step(1, 12, 32'hFFFF_FFF9, 32'h0000_0003, 1, 0); wait_engine();
    // Divide special cases
    step(1, 14, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0); wait_engine();
    step(1, 16, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0); wait_engine();
    step(1, 15, 32'd5, 32'd0, 1, 0); wait_engine();
    step(1, 17, 32'd5, 32'd0, 1, 0); wait_engine();
    step(1, 14, 32'hFFFF_FFF9, 32'd2, 1, 0); wait_engine();
    step(1, 16, 32'hFFFF_FFF9, 32'd2, 1, 0); wait_engine();

    // Output stall: result held for 5 cycles, then the next op issues as it drains
    step(1, 0, 32'd10, 32'd20, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 32'd1, 32'd1, 0, 0);
    step(1, 0, 32'd1, 32'd1, 1, 0);
    step(0, 0, 32'd0, 32'd0, 1, 0);

    // Flush in the middle of a divide
    step(1, 14, 32'd100, 32'd7, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 32'd0, 32'd0, 1, 0);
    step(1, 0, 32'd9, 32'd9, 1, 1);
    #1;
    check("flush_valid", bus.o_valid, 0);
    check("flush_busy", bus.o_busy, 0);
    step(1, 0, 32'd2, 32'd3, 1, 0);
    // Flush while a result is held
    step(1, 4, 32'hF0F0, 32'h0FF0, 0, 0);
    step(0, 0, 32'd0, 32'd0, 0, 0);
    step(0, 0, 32'd0, 32'd0, 0, 1);
    #1;
    check("flush_held_valid", bus.o_valid, 0);
    // Reset in the middle of a divide
    step(1, 14, 32'd100, 32'd7, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 32'd0, 32'd0, 1, 0);
    do_reset();
    step(1, 0, 32'd2, 32'd3, 1, 0);

    // Random traffic with stalls and occasional flushes
    for (int i = 0; i < 250; i++) begin
      int op;
      op = ($urandom_range(0, 9) == 0) ? $urandom_range(18, 31) : $urandom_range(0, 17);
      step($urandom_range(0, 4) != 0, op, pick(), pick(),
           $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    end

    // Drain whatever is outstanding
    for (int i = 0; i < 100 && (q.size() != 0 || m_wait != 0); i++) step(0, 0, 32'd0, 32'd0, 1, 0);
    step(0, 0, 32'd0, 32'd0, 1, 0);
    check("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
